// File: rtl/scene_ctrl_pkg.sv
// Shared game definitions: scene encoding and fade defaults used by the scene controller.
package scene_ctrl_pkg;

  typedef enum logic [2:0] {
    SceneMenu    = 3'd0,
    SceneFadeOut = 3'd1,
    SceneLoad    = 3'd2,
    SceneFadeIn  = 3'd3,
    ScenePlay    = 3'd4
  } scene_t;

  localparam int unsigned FadeFramesDefault = 16;

  // Main stage is held in reset only while the menu owns the screen.
  function automatic logic main_released(input scene_t s);
    return (s != SceneMenu) && (s != SceneFadeOut);
  endfunction

endpackage

// File: rtl/scene_fade.sv
// Per-channel brightness scaling: (chan * level) >> ShiftW, registered once.
module scene_fade #(
  parameter int unsigned ShiftW = 4
) (
  input  logic            i_clk_pix,
  input  logic            i_rst_n,
  input  logic [23:0]     rgb,
  input  logic [ShiftW:0] level,
  output logic [7:0]      red,
  output logic [7:0]      green,
  output logic [7:0]      blue
);

  localparam int unsigned ProdW = 8 + ShiftW + 1;

  logic [7:0] red_d, green_d, blue_d;
  logic [7:0] red_q, green_q, blue_q;

  function automatic logic [7:0] scale(input logic [7:0] chan, input logic [ShiftW:0] lvl);
    logic [ProdW-1:0] prod;
    prod = ProdW'(chan) * ProdW'(lvl);
    return 8'(prod >> ShiftW);
  endfunction

  always_comb begin
    red_d   = scale(rgb[23:16], level);
    green_d = scale(rgb[15:8], level);
    blue_d  = scale(rgb[7:0], level);
  end

  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      red_q   <= 8'h00;
      green_q <= 8'h00;
      blue_q  <= 8'h00;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

endmodule

// File: rtl/scene_ctrl.sv
// Menu -> main stage hand-over: frame-locked fade out, main-stage load, fade in, play.
module scene_ctrl
  import scene_ctrl_pkg::*;
#(
  parameter int unsigned FADE_FRAMES = FadeFramesDefault
) (
  input  logic        i_clk_pix,
  input  logic        i_rst_n,
  input  logic        i_frame,
  input  logic        i_menu_start,
  input  logic [23:0] i_menu_rgb,
  input  logic        i_main_loaded,
  input  logic [23:0] i_main_rgb,
  output logic        o_main_rst_n,
  output logic        o_main_ready,
  output logic [2:0]  o_scene,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue
);

  localparam int unsigned CntW = $clog2(FADE_FRAMES);
  localparam logic [CntW-1:0] CntMax = CntW'(FADE_FRAMES - 1);
  localparam logic [CntW:0] FullLevel = (CntW + 1)'(FADE_FRAMES);

  scene_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            main_rst_n_q;
  logic [23:0]     src_rgb;
  logic [CntW:0]   level;

  // Counter and state move only on frame boundaries, except the two hand-shake exits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    unique case (state_q)
      SceneMenu: begin
        if (i_menu_start) begin
          state_d = SceneFadeOut;
          cnt_d   = '0;
        end
      end
      SceneFadeOut: begin
        if (i_frame) begin
          if (cnt_q == CntMax) begin
            state_d = SceneLoad;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      SceneLoad: begin
        if (i_main_loaded) begin
          state_d = SceneFadeIn;
          cnt_d   = CntMax;
          ready_d = 1'b1;
        end
      end
      SceneFadeIn: begin
        if (i_frame) begin
          if (cnt_q == '0) begin
            state_d = ScenePlay;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      ScenePlay: begin
      end
      default: begin
        state_d = SceneMenu;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      state_q      <= SceneMenu;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      main_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      main_rst_n_q <= main_released(state_d);
    end
  end

  always_comb begin
    src_rgb = i_menu_rgb;
    level   = FullLevel;
    unique case (state_q)
      SceneMenu: begin
      end
      SceneFadeOut: begin
        level = FullLevel - {1'b0, cnt_q};
      end
      SceneLoad: begin
        src_rgb = 24'h000000;
      end
      SceneFadeIn: begin
        src_rgb = i_main_rgb;
        level   = FullLevel - {1'b0, cnt_q};
      end
      ScenePlay: begin
        src_rgb = i_main_rgb;
      end
      default: begin
        src_rgb = 24'h000000;
      end
    endcase
  end

  scene_fade #(
    .ShiftW (CntW)
  ) u_fade (
    .i_clk_pix (i_clk_pix),
    .i_rst_n   (i_rst_n),
    .rgb       (src_rgb),
    .level     (level),
    .red       (o_red),
    .green     (o_green),
    .blue      (o_blue)
  );

  assign o_scene      = state_q;
  assign o_main_ready = ready_q;
  assign o_main_rst_n = main_rst_n_q;

endmodule

// File: tb/tb_scene_ctrl.sv
// Directed bench for scene_ctrl with FADE_FRAMES=4; expected colours are hand-computed.
module tb_scene_ctrl;

  localparam logic [2:0] SMenu    = 3'd0;
  localparam logic [2:0] SFadeOut = 3'd1;
  localparam logic [2:0] SLoad    = 3'd2;
  localparam logic [2:0] SFadeIn  = 3'd3;
  localparam logic [2:0] SPlay    = 3'd4;

  logic        clk;
  logic        rst_n;
  logic        frame;
  logic        menu_start;
  logic [23:0] menu_rgb;
  logic        main_loaded;
  logic [23:0] main_rgb;
  logic        main_rst_n;
  logic        main_ready;
  logic [2:0]  scene;
  logic [7:0]  red, green, blue;

  int n_vec = 0;
  int n_err = 0;

  scene_ctrl #(
    .FADE_FRAMES (4)
  ) dut (
    .i_clk_pix     (clk),
    .i_rst_n       (rst_n),
    .i_frame       (frame),
    .i_menu_start  (menu_start),
    .i_menu_rgb    (menu_rgb),
    .i_main_loaded (main_loaded),
    .i_main_rgb    (main_rgb),
    .o_main_rst_n  (main_rst_n),
    .o_main_ready  (main_ready),
    .o_scene       (scene),
    .o_red         (red),
    .o_green       (green),
    .o_blue        (blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame pulse followed by two idle cycles so the colour register has caught up.
  task automatic frame_pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    frame       = 1'b0;
    menu_start  = 1'b0;
    menu_rgb    = 24'h00FFFF;
    main_loaded = 1'b0;
    main_rgb    = 24'h000000;
    tick();
    tick();
    check_eq("rst_scene", 24'(scene), 24'(SMenu));
    check_eq("rst_ready", 24'(main_ready), 24'd0);
    check_eq("rst_mainrst", 24'(main_rst_n), 24'd0);
    check_eq("rst_rgb", {red, green, blue}, 24'h000000);

    // Idle menu
    rst_n = 1'b1;
    tick();
    check_eq("menu_latency", {red, green, blue}, 24'h00FFFF);
    for (int i = 0; i < 10; i++) frame_pulse();
    check_eq("menu_scene", 24'(scene), 24'(SMenu));
    check_eq("menu_rgb", {red, green, blue}, 24'h00FFFF);
    check_eq("menu_mainrst", 24'(main_rst_n), 24'd0);
    check_eq("menu_ready", 24'(main_ready), 24'd0);

    // Fade out
    menu_rgb   = 24'h808080;
    menu_start = 1'b1;
    tick();
    menu_start = 1'b0;
    tick();
    check_eq("fo_scene", 24'(scene), 24'(SFadeOut));
    check_eq("fo_mainrst", 24'(main_rst_n), 24'd0);
    check_eq("fo_l4", {red, green, blue}, 24'h808080);
    frame_pulse();
    check_eq("fo_l3", {red, green, blue}, 24'h606060);
    frame_pulse();
    check_eq("fo_l2", {red, green, blue}, 24'h404040);
    frame_pulse();
    check_eq("fo_l1", {red, green, blue}, 24'h202020);
    frame_pulse();
    check_eq("load_scene", 24'(scene), 24'(SLoad));
    check_eq("load_rgb", {red, green, blue}, 24'h000000);
    check_eq("load_mainrst", 24'(main_rst_n), 24'd1);
    check_eq("load_ready", 24'(main_ready), 24'd0);

    // Load waits on the main stage
    main_rgb = 24'hFF0000;
    for (int i = 0; i < 20; i++) frame_pulse();
    check_eq("load_hold_scene", 24'(scene), 24'(SLoad));
    check_eq("load_hold_rgb", {red, green, blue}, 24'h000000);
    main_loaded = 1'b1;
    tick();
    check_eq("fi_scene", 24'(scene), 24'(SFadeIn));
    check_eq("fi_ready", 24'(main_ready), 24'd1);
    tick();
    check_eq("fi_l1", {red, green, blue}, 24'h3F0000);
    frame_pulse();
    check_eq("fi_l2", {red, green, blue}, 24'h7F0000);
    frame_pulse();
    check_eq("fi_l3", {red, green, blue}, 24'hBF0000);
    frame_pulse();
    check_eq("fi_l4", {red, green, blue}, 24'hFF0000);
    frame_pulse();
    check_eq("play_scene", 24'(scene), 24'(SPlay));
    check_eq("play_rgb", {red, green, blue}, 24'hFF0000);
    check_eq("play_mainrst", 24'(main_rst_n), 24'd1);

    // Play is terminal
    menu_start = 1'b1;
    main_loaded = 1'b0;
    frame_pulse();
    frame_pulse();
    menu_start = 1'b0;
    check_eq("play_terminal", 24'(scene), 24'(SPlay));
    check_eq("play_ready_sticky", 24'(main_ready), 24'd1);

    // Reset from play
    rst_n = 1'b0;
    tick();
    check_eq("rstplay_scene", 24'(scene), 24'(SMenu));
    check_eq("rstplay_ready", 24'(main_ready), 24'd0);
    check_eq("rstplay_mainrst", 24'(main_rst_n), 24'd0);
    check_eq("rstplay_rgb", {red, green, blue}, 24'h000000);

    // Reset during fade-out at count 2
    rst_n      = 1'b1;
    menu_start = 1'b1;
    tick();
    menu_start = 1'b0;
    frame_pulse();
    frame_pulse();
    check_eq("mid_fade_rgb", {red, green, blue}, 24'h404040);
    rst_n = 1'b0;
    tick();
    check_eq("rstfade_scene", 24'(scene), 24'(SMenu));
    check_eq("rstfade_ready", 24'(main_ready), 24'd0);
    check_eq("rstfade_mainrst", 24'(main_rst_n), 24'd0);
    check_eq("rstfade_rgb", {red, green, blue}, 24'h000000);
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("rstfade_full", {red, green, blue}, 24'h808080);

    // Start coincident with frame, main_loaded held high through reset
    main_loaded = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("early_scene", 24'(scene), 24'(SMenu));
    menu_start = 1'b1;
    frame      = 1'b1;
    tick();
    menu_start = 1'b0;
    frame      = 1'b0;
    check_eq("coinc_scene", 24'(scene), 24'(SFadeOut));
    tick();
    check_eq("coinc_cnt0", {red, green, blue}, 24'h808080);
    frame_pulse();
    frame_pulse();
    frame_pulse();
    check_eq("coinc_no_early_load", 24'(scene), 24'(SFadeOut));
    check_eq("coinc_l1", {red, green, blue}, 24'h202020);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    check_eq("short_load_scene", 24'(scene), 24'(SLoad));
    check_eq("short_load_mainrst", 24'(main_rst_n), 24'd1);
    tick();
    check_eq("short_load_exit", 24'(scene), 24'(SFadeIn));
    check_eq("short_load_ready", 24'(main_ready), 24'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
